// File: rtl/noc_link_pipeline.sv
// noc_link_pipeline: one direction of a credit-based NoC link.
//
// The forward flit bundle {data, dest, is_tail, send} and the reverse credit each pass
// through NUM_PIPELINE register stages. The stages advance every cycle with no stalls;
// the sender is throttled only by credits. A NUM_PIPELINE of 0 makes both paths plain
// wires.
//
// An upstream-side monitor watches send_in and the retimed credit_out. It tracks:
//   - the credits still available downstream,
//   - packet framing,
//   - flit and packet counts.
// It raises sticky error flags on credit underflow, credit overflow and a destination
// change inside a packet.
//
// Ports:
//   clk_noc, rst_noc            clock; asynchronous active-high reset
//   data_in/dest_in/is_tail_in/send_in     flit from the router output
//   data_out/dest_out/is_tail_out/send_out retimed flit to the downstream router
//   credit_in                   credit from the downstream router
//   credit_out                  retimed credit back to the router output
//   clr_stats                   synchronous clear of counters and error flags
//   credit_count                credits currently available upstream
//   flit_count, pkt_count       accepted flits and packets (wrap around)
//   in_packet                   a head has been seen and its tail has not
//   err_no_credit, err_credit_ovf, err_dest_mismatch   sticky error flags
module noc_link_pipeline #(
  parameter int unsigned NUM_PIPELINE      = 1,
  parameter int unsigned FLIT_WIDTH        = 64,
  parameter int unsigned DEST_WIDTH        = 4,
  parameter int unsigned FLIT_BUFFER_DEPTH = 4,
  parameter int unsigned CNT_WIDTH         = 16,
  localparam int unsigned CRED_W           = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                  clk_noc,
  input  logic                  rst_noc,
  input  logic [FLIT_WIDTH-1:0] data_in,
  input  logic [DEST_WIDTH-1:0] dest_in,
  input  logic                  is_tail_in,
  input  logic                  send_in,
  output logic                  credit_out,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic [DEST_WIDTH-1:0] dest_out,
  output logic                  is_tail_out,
  output logic                  send_out,
  input  logic                  credit_in,
  input  logic                  clr_stats,
  output logic [CRED_W-1:0]     credit_count,
  output logic [CNT_WIDTH-1:0]  flit_count,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic                  in_packet,
  output logic                  err_no_credit,
  output logic                  err_credit_ovf,
  output logic                  err_dest_mismatch
);

  localparam int unsigned BundleW = FLIT_WIDTH + DEST_WIDTH + 2;
  localparam logic [CRED_W-1:0] CredMax = CRED_W'(FLIT_BUFFER_DEPTH);

  if (NUM_PIPELINE > 4) begin : g_bad_depth
    $error("NUM_PIPELINE must be in 0..4");
  end

  logic [BundleW-1:0] fwd_in, fwd_out;
  assign fwd_in = {data_in, dest_in, is_tail_in, send_in};

  // ---------------------------------------------------------------------------------------
  // Retiming chains
  // ---------------------------------------------------------------------------------------
  if (NUM_PIPELINE == 0) begin : g_wire
    assign fwd_out    = fwd_in;
    assign credit_out = credit_in;
  end else begin : g_pipe
    logic [BundleW-1:0] fwd_d  [NUM_PIPELINE];
    logic [BundleW-1:0] fwd_q  [NUM_PIPELINE];
    logic               cred_d [NUM_PIPELINE];
    logic               cred_q [NUM_PIPELINE];

    always_comb begin
      fwd_d[0]  = fwd_in;
      cred_d[0] = credit_in;
      for (int i = 1; i < NUM_PIPELINE; i++) begin
        fwd_d[i]  = fwd_q[i-1];
        cred_d[i] = cred_q[i-1];
      end
    end

    // Data stages are reset as well, so a reset discards every in-flight flit and credit.
    always_ff @(posedge clk_noc or posedge rst_noc) begin
      if (rst_noc) begin
        for (int i = 0; i < NUM_PIPELINE; i++) begin
          fwd_q[i]  <= '0;
          cred_q[i] <= 1'b0;
        end
      end else begin
        fwd_q  <= fwd_d;
        cred_q <= cred_d;
      end
    end

    assign fwd_out    = fwd_q[NUM_PIPELINE-1];
    assign credit_out = cred_q[NUM_PIPELINE-1];
  end

  assign {data_out, dest_out, is_tail_out, send_out} = fwd_out;

  // ---------------------------------------------------------------------------------------
  // Link monitor
  // ---------------------------------------------------------------------------------------
  logic [CRED_W-1:0]     credit_count_d, credit_count_q;
  logic [CNT_WIDTH-1:0]  flit_count_d, flit_count_q;
  logic [CNT_WIDTH-1:0]  pkt_count_d, pkt_count_q;
  logic                  in_packet_d, in_packet_q;
  logic [DEST_WIDTH-1:0] head_dest_d, head_dest_q;
  logic                  err_no_credit_d, err_no_credit_q;
  logic                  err_credit_ovf_d, err_credit_ovf_q;
  logic                  err_dest_mismatch_d, err_dest_mismatch_q;

  always_comb begin
    credit_count_d      = credit_count_q;
    flit_count_d        = flit_count_q;
    pkt_count_d         = pkt_count_q;
    in_packet_d         = in_packet_q;
    head_dest_d         = head_dest_q;
    err_no_credit_d     = err_no_credit_q;
    err_credit_ovf_d    = err_credit_ovf_q;
    err_dest_mismatch_d = err_dest_mismatch_q;

    // A send and a returning credit in the same cycle cancel out.
    if (send_in && !credit_out) begin
      if (credit_count_q == '0) begin
        err_no_credit_d = 1'b1;
      end else begin
        credit_count_d = credit_count_q - CRED_W'(1);
      end
    end else if (credit_out && !send_in) begin
      if (credit_count_q == CredMax) begin
        err_credit_ovf_d = 1'b1;
      end else begin
        credit_count_d = credit_count_q + CRED_W'(1);
      end
    end

    if (send_in) begin
      flit_count_d = flit_count_q + CNT_WIDTH'(1);
      if (is_tail_in) begin
        pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
      end
      if (!in_packet_q) begin
        head_dest_d = dest_in;
        in_packet_d = !is_tail_in;
      end else begin
        if (dest_in != head_dest_q) begin
          err_dest_mismatch_d = 1'b1;
        end
        if (is_tail_in) begin
          in_packet_d = 1'b0;
        end
      end
    end

    // The clear wins over same-cycle events. It leaves the credit count and framing alone.
    if (clr_stats) begin
      flit_count_d        = '0;
      pkt_count_d         = '0;
      err_no_credit_d     = 1'b0;
      err_credit_ovf_d    = 1'b0;
      err_dest_mismatch_d = 1'b0;
    end
  end

  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      credit_count_q      <= CredMax;
      flit_count_q        <= '0;
      pkt_count_q         <= '0;
      in_packet_q         <= 1'b0;
      head_dest_q         <= '0;
      err_no_credit_q     <= 1'b0;
      err_credit_ovf_q    <= 1'b0;
      err_dest_mismatch_q <= 1'b0;
    end else begin
      credit_count_q      <= credit_count_d;
      flit_count_q        <= flit_count_d;
      pkt_count_q         <= pkt_count_d;
      in_packet_q         <= in_packet_d;
      head_dest_q         <= head_dest_d;
      err_no_credit_q     <= err_no_credit_d;
      err_credit_ovf_q    <= err_credit_ovf_d;
      err_dest_mismatch_q <= err_dest_mismatch_d;
    end
  end

  assign credit_count      = credit_count_q;
  assign flit_count        = flit_count_q;
  assign pkt_count         = pkt_count_q;
  assign in_packet         = in_packet_q;
  assign err_no_credit     = err_no_credit_q;
  assign err_credit_ovf    = err_credit_ovf_q;
  assign err_dest_mismatch = err_dest_mismatch_q;

endmodule

// File: tb/tb_noc_link_pipeline.sv
module tb_noc_link_pipeline;

  logic        clk_noc = 1'b0;
  logic        rst_noc;
  logic [63:0] data_in;
  logic [3:0]  dest_in;
  logic        is_tail_in, send_in, credit_in, clr_stats;

  // Two-stage instance
  logic        credit_out, is_tail_out, send_out, in_packet;
  logic [63:0] data_out;
  logic [3:0]  dest_out;
  logic [2:0]  credit_count;
  logic [15:0] flit_count, pkt_count;
  logic        err_no_credit, err_credit_ovf, err_dest_mismatch;

  // Zero-stage instance
  logic        z_credit_out, z_is_tail_out, z_send_out, z_in_packet;
  logic [63:0] z_data_out;
  logic [3:0]  z_dest_out;
  logic [2:0]  z_credit_count;
  logic [15:0] z_flit_count, z_pkt_count;
  logic        z_err_no_credit, z_err_credit_ovf, z_err_dest_mismatch;

  int checks = 0;
  int failures = 0;

  always #5 clk_noc = ~clk_noc;

  noc_link_pipeline #(.NUM_PIPELINE(2)) dut (
    .clk_noc(clk_noc), .rst_noc(rst_noc), .data_in(data_in), .dest_in(dest_in),
    .is_tail_in(is_tail_in), .send_in(send_in), .credit_out(credit_out),
    .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
    .send_out(send_out), .credit_in(credit_in), .clr_stats(clr_stats),
    .credit_count(credit_count), .flit_count(flit_count), .pkt_count(pkt_count),
    .in_packet(in_packet), .err_no_credit(err_no_credit), .err_credit_ovf(err_credit_ovf),
    .err_dest_mismatch(err_dest_mismatch)
  );

  noc_link_pipeline #(.NUM_PIPELINE(0)) dut0 (
    .clk_noc(clk_noc), .rst_noc(rst_noc), .data_in(data_in), .dest_in(dest_in),
    .is_tail_in(is_tail_in), .send_in(send_in), .credit_out(z_credit_out),
    .data_out(z_data_out), .dest_out(z_dest_out), .is_tail_out(z_is_tail_out),
    .send_out(z_send_out), .credit_in(credit_in), .clr_stats(clr_stats),
    .credit_count(z_credit_count), .flit_count(z_flit_count), .pkt_count(z_pkt_count),
    .in_packet(z_in_packet), .err_no_credit(z_err_no_credit),
    .err_credit_ovf(z_err_credit_ovf), .err_dest_mismatch(z_err_dest_mismatch)
  );

  typedef struct {
    logic        send;
    logic        tail;
    logic        ci;
    logic        clr;
    logic [3:0]  dest;
    logic [2:0]  exp_cc;
    logic [15:0] exp_flit;
    logic [15:0] exp_pkt;
    logic        exp_inpkt;
    logic [2:0]  exp_err;  // {no_credit, credit_ovf, dest_mismatch}
  } vec_t;

  vec_t vq[$];
  logic        h_send [64];
  logic        h_tail [64];
  logic        h_ci   [64];
  logic [3:0]  h_dest [64];
  logic [63:0] h_data [64];

  function automatic void add(logic send, logic tail, logic ci, logic clr, logic [3:0] dest,
                              logic [2:0] cc, int flit, int pkt, logic inp, logic [2:0] err);
    vec_t v;
    v.send = send; v.tail = tail; v.ci = ci; v.clr = clr; v.dest = dest;
    v.exp_cc = cc; v.exp_flit = 16'(flit); v.exp_pkt = 16'(pkt);
    v.exp_inpkt = inp; v.exp_err = err;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    send_in = 1'b0; is_tail_in = 1'b0; dest_in = '0; data_in = '0;
    credit_in = 1'b0; clr_stats = 1'b0;
  endtask

  initial begin
    logic        es, et, ec;
    logic [3:0]  ed;
    logic [63:0] edata;

    // send tail ci clr dest  cc flit pkt inp err
    add(1, 0, 0, 0, 4'h5, 3, 1, 0, 1, 3'b000);   // 0: head, dest 5
    add(1, 0, 0, 0, 4'h5, 2, 2, 0, 1, 3'b000);   // 1: body
    add(1, 1, 0, 0, 4'h5, 1, 3, 1, 0, 3'b000);   // 2: tail
    add(0, 0, 0, 0, 4'h0, 1, 3, 1, 0, 3'b000);   // 3: idle
    add(1, 1, 0, 0, 4'h2, 0, 4, 2, 0, 3'b000);   // 4: single-flit packet
    add(1, 1, 0, 0, 4'h1, 0, 5, 3, 0, 3'b100);   // 5: send with no credit
    add(0, 0, 1, 0, 4'h0, 0, 5, 3, 0, 3'b100);   // 6: credit_in, arrives at 8
    add(0, 0, 1, 0, 4'h0, 0, 5, 3, 0, 3'b100);   // 7
    add(0, 0, 1, 0, 4'h0, 1, 5, 3, 0, 3'b100);   // 8: credit_out -> 1
    add(0, 0, 1, 0, 4'h0, 2, 5, 3, 0, 3'b100);   // 9: credit_out -> 2
    // 10..19: send and credit_out together every cycle, one 10-flit packet, dest 4
    for (int k = 0; k < 10; k++) begin
      add(1, (k == 9), (k < 8), 0, 4'h4, 2, 6 + k, (k == 9) ? 4 : 3, (k != 9), 3'b100);
    end
    add(0, 0, 1, 0, 4'h0, 2, 15, 4, 0, 3'b100);  // 20
    add(0, 0, 1, 0, 4'h0, 2, 15, 4, 0, 3'b100);  // 21
    add(0, 0, 1, 0, 4'h0, 3, 15, 4, 0, 3'b100);  // 22
    add(0, 0, 0, 0, 4'h0, 4, 15, 4, 0, 3'b100);  // 23
    add(0, 0, 0, 0, 4'h0, 4, 15, 4, 0, 3'b110);  // 24: credit at full count
    add(1, 0, 0, 1, 4'h3, 3, 0, 0, 1, 3'b000);   // 25: clear while sending a head, dest 3
    add(1, 0, 0, 0, 4'h7, 2, 1, 0, 1, 3'b001);   // 26: body with dest 7
    add(1, 1, 0, 0, 4'h3, 1, 2, 1, 0, 3'b001);   // 27: tail
    add(1, 1, 0, 0, 4'h9, 0, 3, 2, 0, 3'b001);   // 28: head+tail
    add(0, 0, 0, 0, 4'h0, 0, 3, 2, 0, 3'b001);   // 29

    rst_noc = 1'b1;
    drive_idle();
    repeat (3) @(posedge clk_noc);
    @(negedge clk_noc);
    rst_noc = 1'b0;
    #1;
    chk("reset send_out", 64'(send_out), 64'd0);
    chk("reset credit_out", 64'(credit_out), 64'd0);
    chk("reset data_out", data_out, 64'd0);
    chk("reset credit_count", 64'(credit_count), 64'd4);
    chk("reset z_credit_count", 64'(z_credit_count), 64'd4);
    chk("reset flit_count", 64'(flit_count), 64'd0);
    chk("reset pkt_count", 64'(pkt_count), 64'd0);
    chk("reset in_packet", 64'(in_packet), 64'd0);
    chk("reset errors", 64'({err_no_credit, err_credit_ovf, err_dest_mismatch}), 64'd0);
    repeat (2) @(posedge clk_noc);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk_noc);
      send_in    = vq[i].send;
      is_tail_in = vq[i].tail;
      dest_in    = vq[i].dest;
      credit_in  = vq[i].ci;
      clr_stats  = vq[i].clr;
      data_in    = {32'hDA7A_0000 + 32'(i), 32'h1234_5678 ^ 32'(i)};
      h_send[i] = send_in; h_tail[i] = is_tail_in; h_ci[i] = credit_in;
      h_dest[i] = dest_in; h_data[i] = data_in;
      #1;
      es = (i >= 2) ? h_send[i-2] : 1'b0;
      ec = (i >= 2) ? h_ci[i-2]   : 1'b0;
      chk($sformatf("v%0d send_out", i), 64'(send_out), 64'(es));
      chk($sformatf("v%0d credit_out", i), 64'(credit_out), 64'(ec));
      if (es) begin
        et = h_tail[i-2]; ed = h_dest[i-2]; edata = h_data[i-2];
        chk($sformatf("v%0d data_out", i), data_out, edata);
        chk($sformatf("v%0d dest_out", i), 64'(dest_out), 64'(ed));
        chk($sformatf("v%0d is_tail_out", i), 64'(is_tail_out), 64'(et));
      end
      chk($sformatf("v%0d z_send_out", i), 64'(z_send_out), 64'(vq[i].send));
      chk($sformatf("v%0d z_credit_out", i), 64'(z_credit_out), 64'(vq[i].ci));
      chk($sformatf("v%0d z_data_out", i), z_data_out, h_data[i]);
      chk($sformatf("v%0d z_dest_tail", i), 64'({z_dest_out, z_is_tail_out}),
          64'({vq[i].dest, vq[i].tail}));
      @(posedge clk_noc);
      #1;
      chk($sformatf("v%0d credit_count", i), 64'(credit_count), 64'(vq[i].exp_cc));
      chk($sformatf("v%0d flit_count", i), 64'(flit_count), 64'(vq[i].exp_flit));
      chk($sformatf("v%0d pkt_count", i), 64'(pkt_count), 64'(vq[i].exp_pkt));
      chk($sformatf("v%0d in_packet", i), 64'(in_packet), 64'(vq[i].exp_inpkt));
      chk($sformatf("v%0d errors", i),
          64'({err_no_credit, err_credit_ovf, err_dest_mismatch}), 64'(vq[i].exp_err));
    end

    // Reset mid-packet with a flit and a credit in flight.
    @(negedge clk_noc);
    drive_idle();
    send_in = 1'b1; dest_in = 4'h1; credit_in = 1'b1; data_in = 64'hFEED_0001;
    @(negedge clk_noc);
    send_in = 1'b1; dest_in = 4'h1; credit_in = 1'b1; data_in = 64'hFEED_0002;
    @(negedge clk_noc);
    drive_idle();
    #1;
    chk("pre-reset send_out", 64'(send_out), 64'd1);
    chk("pre-reset data_out", data_out, 64'hFEED_0001);
    chk("pre-reset credit_out", 64'(credit_out), 64'd1);
    chk("pre-reset in_packet", 64'(in_packet), 64'd1);
    rst_noc = 1'b1;
    #1;
    chk("async reset send_out", 64'(send_out), 64'd0);
    chk("async reset credit_out", 64'(credit_out), 64'd0);
    chk("async reset in_packet", 64'(in_packet), 64'd0);
    chk("async reset credit_count", 64'(credit_count), 64'd4);
    chk("async reset flit_count", 64'(flit_count), 64'd0);
    chk("async reset errors", 64'({err_no_credit, err_credit_ovf, err_dest_mismatch}), 64'd0);
    @(negedge clk_noc);
    rst_noc = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_noc);
      #1;
      chk($sformatf("post-reset send_out %0d", k), 64'(send_out), 64'd0);
      chk($sformatf("post-reset credit_out %0d", k), 64'(credit_out), 64'd0);
      chk($sformatf("post-reset credit_count %0d", k), 64'(credit_count), 64'd4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
